dmem_arbiter: RTL

Two-requester arbiter that shares the single data RAM between the CPU load/store path and a debug/program loader port. It sits between the memory stage, the loader and the RAM, and stalls the CPU while the loader owns the RAM. Arbitration is round-robin with an optional loader burst lock, bounded by a starvation limit. Read data is returned through a registered response stage.

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_rr_pick2.sv | 33 +++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-RAM arbiter: owner state,
// response tag and hold counter width.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LD   = 2'd2
  } owner_e;

  typedef enum logic {
    TAG_CPU = 1'b0,
    TAG_LD  = 1'b1
  } tag_e;

  localparam int HOLD_W = 8;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way winner select: round-robin with loader lock,
// overridden once the holder has used up its hold budget.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  owner_e     owner_i,
  input  logic       lock_i,
  input  logic       hold_expired_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (req0_i & ~req1_i): gnt_o = 2'b01;
      (req1_i & ~req0_i): gnt_o = 2'b10;
      (req0_i & req1_i): begin
        unique case (owner_i)
          OWN_CPU: gnt_o = 2'b10;
          OWN_LD: begin
            if (lock_i & ~hold_expired_i) gnt_o = 2'b10;
            else                          gnt_o = 2'b01;
          end
          default: gnt_o = 2'b01;
        endcase
      end
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data RAM between the CPU load/store path and
// the loader port; read data returns one cycle after grant.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_CpuReq_1,
  input  logic              i_CpuWe_1,
  input  logic [ADDR_W-1:0] i_CpuAddr_32,
  input  logic [31:0]       i_CpuWdata_32,
  output logic              o_CpuGnt_1,
  output logic              o_CpuStall_1,
  output logic              o_CpuRvalid_1,
  output logic [31:0]       o_CpuRdata_32,
  input  logic              i_LdReq_1,
  input  logic              i_LdWe_1,
  input  logic [ADDR_W-1:0] i_LdAddr_32,
  input  logic [31:0]       i_LdWdata_32,
  input  logic              i_LdLock_1,
  output logic              o_LdGnt_1,
  output logic              o_LdRvalid_1,
  output logic [31:0]       o_LdRdata_32,
  output logic [ADDR_W-1:0] o_MemAddr_32,
  output logic [31:0]       o_MemWdata_32,
  output logic              o_MemWe_1,
  input  logic [31:0]       i_MemRdata_32
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [1:0]        pick;
  logic [1:0]        gnt;
  owner_e            owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              hold_expired;
  logic              win_we;
  logic              other_wait;
  logic              rvalid_q, rvalid_d;
  tag_e              tag_q, tag_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       ld_rdata_q, ld_rdata_d;

  assign hold_expired = (hold_q >= HOLD_MAX);

  rr_pick2 u_pick (
    .req0_i         (i_CpuReq_1),
    .req1_i         (i_LdReq_1),
    .owner_i        (owner_q),
    .lock_i         (i_LdLock_1),
    .hold_expired_i (hold_expired),
    .gnt_o          (pick)
  );

  // Grants must vanish the moment reset asserts, not at the next edge.
  assign gnt          = pick & {2{rstn}};
  assign o_CpuGnt_1   = gnt[0];
  assign o_LdGnt_1    = gnt[1];
  assign o_CpuStall_1 = i_CpuReq_1 & ~gnt[0];
  assign o_MemWe_1    = win_we;

  always_comb begin
    o_MemAddr_32  = '0;
    o_MemWdata_32 = '0;
    win_we        = 1'b0;
    other_wait    = 1'b0;
    owner_d       = owner_q;
    if (gnt[0]) begin
      o_MemAddr_32  = i_CpuAddr_32;
      o_MemWdata_32 = i_CpuWdata_32;
      win_we        = i_CpuWe_1;
      other_wait    = i_LdReq_1;
      owner_d       = OWN_CPU;
    end else if (gnt[1]) begin
      o_MemAddr_32  = i_LdAddr_32;
      o_MemWdata_32 = i_LdWdata_32;
      win_we        = i_LdWe_1;
      other_wait    = i_CpuReq_1;
      owner_d       = OWN_LD;
    end
  end

  always_comb begin
    hold_d = '0;
    if ((|gnt) && (owner_d == owner_q) && other_wait) begin
      if (hold_expired) hold_d = hold_q;
      else              hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_comb begin
    rvalid_d    = (|gnt) & ~win_we;
    tag_d       = tag_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    if (gnt[0] & ~i_CpuWe_1) begin
      tag_d       = TAG_CPU;
      cpu_rdata_d = i_MemRdata_32;
    end else if (gnt[1] & ~i_LdWe_1) begin
      tag_d      = TAG_LD;
      ld_rdata_d = i_MemRdata_32;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_q     <= OWN_NONE;
      hold_q      <= '0;
      rvalid_q    <= 1'b0;
      tag_q       <= TAG_CPU;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      rvalid_q    <= rvalid_d;
      tag_q       <= tag_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  assign o_CpuRvalid_1 = rvalid_q & (tag_q == TAG_CPU);
  assign o_LdRvalid_1  = rvalid_q & (tag_q == TAG_LD);
  assign o_CpuRdata_32 = cpu_rdata_q;
  assign o_LdRdata_32  = ld_rdata_q;

endmodule
